// File: rtl/vape_pkg.sv
// Shared definitions for the VAPE METADATA writer: register word offsets,
// CTRL/STATUS bit positions, commit FSM state encoding and the bounds bundle.
package vape_pkg;

  // Word index = byte offset >> 1 within the 16-byte window.
  localparam logic [2:0] OFF_ER_MIN = 3'd0;
  localparam logic [2:0] OFF_ER_MAX = 3'd1;
  localparam logic [2:0] OFF_OR_MIN = 3'd2;
  localparam logic [2:0] OFF_OR_MAX = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_CLR_ERR = 1;

  localparam int STAT_EXEC      = 0;
  localparam int STAT_ERR       = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_CFG_VALID = 3;
  localparam int STAT_DROP      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_APPLY = 2'd2
  } meta_state_e;

  typedef struct packed {
    logic [15:0] er_min;
    logic [15:0] er_max;
    logic [15:0] or_min;
    logic [15:0] or_max;
  } meta_bounds_t;

endpackage

// File: rtl/vape_meta_check.sv
// Combinational METADATA sanity check: both ranges well-formed (unsigned) and
// the output region strictly disjoint from the executable region.
module vape_meta_check (
  input  logic [15:0] er_min,
  input  logic [15:0] er_max,
  input  logic [15:0] or_min,
  input  logic [15:0] or_max,
  output logic        ok
);

  logic er_ordered;
  logic or_ordered;
  logic disjoint;

  assign er_ordered = (er_min <= er_max);
  assign or_ordered = (or_min <= or_max);
  // Touching ranges share an address, so strict comparisons are required.
  assign disjoint   = (or_max < er_min) || (or_min > er_max);
  assign ok         = er_ordered && or_ordered && disjoint;

endmodule

// File: rtl/vape_meta_cfg.sv
// VAPE METADATA register block on the openMSP430 peripheral bus: stage shadow
// bounds, validate, commit. Optional macro VAPE_META_LOCK_EN blocks writes while exec=1.
module vape_meta_cfg
  import vape_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0190
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic        per_we,
  output logic [15:0] per_dout,
  input  logic        exec,
  output logic [15:0] er_min,
  output logic [15:0] er_max,
  output logic [15:0] or_min,
  output logic [15:0] or_max,
  output logic        meta_upd,
  output logic        cfg_valid,
  output meta_state_e state_dbg
);

  // Bus handshake: an access is a single cycle with per_en high; writes take
  // effect on that rising edge, reads return per_dout combinationally in the
  // same cycle. There is no wait state and no back-pressure.

  meta_state_e  state, state_nxt;
  meta_bounds_t shadow;
  meta_bounds_t committed;
  logic         err;
  logic         drop;
  logic         busy;
  logic         locked;
  logic         ok;
  logic         load_commit;
  logic         set_err;

  logic         hit;
  logic [2:0]   word;
  logic         shadow_wr;
  logic         commit_req;
  logic         clr_req;
  logic         blocked;
  logic         accept_shadow;
  logic         accept_commit;
  logic         drop_evt;
  logic [15:0]  rd_data;
  logic         unused_addr_lsb;

  assign unused_addr_lsb = per_addr[0];

  assign hit        = per_en && (per_addr[15:4] == BASE_ADDR[15:4]);
  assign word       = per_addr[3:1];
  assign shadow_wr  = hit && per_we && (word[2] == 1'b0);
  assign commit_req = hit && per_we && (word == OFF_CTRL) && per_din[CTRL_COMMIT];
  assign clr_req    = hit && per_we && (word == OFF_CTRL) && per_din[CTRL_CLR_ERR];

`ifdef VAPE_META_LOCK_EN
  assign locked = exec;
`else
  assign locked = 1'b0;
`endif

  assign busy          = (state != ST_IDLE);
  assign blocked       = busy || locked;
  assign accept_shadow = shadow_wr && !blocked;
  assign accept_commit = commit_req && !blocked;
  assign drop_evt      = (shadow_wr || commit_req) && blocked;

  vape_meta_check u_check (
    .er_min (shadow.er_min),
    .er_max (shadow.er_max),
    .or_min (shadow.or_min),
    .or_max (shadow.or_max),
    .ok     (ok)
  );

  // Committed bounds load at the end of CHECK so they are visible in the
  // APPLY cycle together with meta_upd (two cycles after the COMMIT write).
  always_comb begin
    state_nxt   = state;
    load_commit = 1'b0;
    set_err     = 1'b0;
    meta_upd    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_commit) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (ok) begin
          load_commit = 1'b1;
          state_nxt   = ST_APPLY;
        end else begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_APPLY: begin
        meta_upd  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      committed <= '0;
      err       <= 1'b0;
      drop      <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_shadow) begin
        case (word)
          OFF_ER_MIN: shadow.er_min <= per_din;
          OFF_ER_MAX: shadow.er_max <= per_din;
          OFF_OR_MIN: shadow.or_min <= per_din;
          default:    shadow.or_max <= per_din;
        endcase
      end
      if (load_commit) begin
        committed <= shadow;
        cfg_valid <= 1'b1;
      end
      // Clear applies before any new error or drop raised in the same cycle.
      err  <= set_err  || (err  && !clr_req);
      drop <= drop_evt || (drop && !clr_req);
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    case (word)
      OFF_ER_MIN: rd_data = shadow.er_min;
      OFF_ER_MAX: rd_data = shadow.er_max;
      OFF_OR_MIN: rd_data = shadow.or_min;
      OFF_OR_MAX: rd_data = shadow.or_max;
      OFF_STATUS: begin
        rd_data[STAT_EXEC]      = exec;
        rd_data[STAT_ERR]       = err;
        rd_data[STAT_BUSY]      = busy;
        rd_data[STAT_CFG_VALID] = cfg_valid;
        rd_data[STAT_DROP]      = drop;
      end
      default: rd_data = 16'h0000;
    endcase
  end

  assign per_dout  = (hit && !per_we) ? rd_data : 16'h0000;
  assign er_min    = committed.er_min;
  assign er_max    = committed.er_max;
  assign or_min    = committed.or_min;
  assign or_max    = committed.or_max;
  assign state_dbg = state;

endmodule

// File: tb/tb_vape_meta_cfg.sv
// Directed bench for vape_meta_cfg: stimulus pushes expected reads and commits
// into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_vape_meta_cfg;
  import vape_pkg::*;

  localparam logic [15:0] BASE = 16'h0190;

  logic        clk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [15:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic        per_we = 1'b0;
  logic [15:0] per_dout;
  logic        exec = 1'b0;
  logic [15:0] er_min, er_max, or_min, or_max;
  logic        meta_upd;
  logic        cfg_valid;
  meta_state_e state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [63:0] exp_commit_q[$];
  int          exp_cyc_q[$];

  vape_meta_cfg #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .puc_rst   (puc_rst),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout),
    .exec      (exec),
    .er_min    (er_min),
    .er_max    (er_max),
    .or_min    (or_min),
    .or_max    (or_max),
    .meta_upd  (meta_upd),
    .cfg_valid (cfg_valid),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks: each drives one bus cycle starting just after a rising edge.
  task automatic idle();
    @(posedge clk); #1;
    per_en = 1'b0; per_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [15:0] d);
    @(posedge clk); #1;
    per_en = 1'b1; per_we = 1'b1; per_addr = BASE + {12'h0, off}; per_din = d;
  endtask

  task automatic rd_addr(input logic [15:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    per_en = 1'b1; per_we = 1'b0; per_addr = a; per_din = 16'h0;
    exp_q.push_back(exp);
  endtask

  task automatic rd(input logic [3:0] off, input logic [15:0] exp);
    rd_addr(BASE + {12'h0, off}, exp);
  endtask

  task automatic ctrl_commit(input logic [15:0] d, input logic [63:0] exp_b);
    wr(4'h8, d);
    exp_commit_q.push_back(exp_b);
    exp_cyc_q.push_back(cyc + 2);
  endtask

  task automatic reset_dut(input int n);
    @(posedge clk); #1;
    puc_rst = 1'b1; per_en = 1'b0; per_we = 1'b0;
    repeat (n) @(posedge clk);
    #1 puc_rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!puc_rst) begin
      if (per_en && !per_we) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL read_unexpected: addr %0h got %0h with no expectation", per_addr, per_dout);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk($sformatf("read_%0h", per_addr), {48'h0, per_dout}, {48'h0, e});
        end
      end
      if (meta_upd) begin
        if (exp_commit_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL meta_upd_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          logic [63:0] eb;
          int          ec;
          eb = exp_commit_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("commit_bounds", {er_min, er_max, or_min, or_max}, eb);
          chk("commit_latency", 64'(cyc), 64'(ec));
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset_dut(3);
    @(negedge clk);
    chk("rst_bounds", {er_min, er_max, or_min, or_max}, 64'h0);
    chk("rst_cfg_valid", {63'h0, cfg_valid}, 64'h0);
    chk("rst_meta_upd", {63'h0, meta_upd}, 64'h0);
    for (int i = 0; i < 16; i += 2) rd(4'(i), 16'h0000);
    rd_addr(16'h0200, 16'h0000);

    // Valid commit with busy/cfg_valid visible through STATUS
    wr(4'h0, 16'hE000); wr(4'h2, 16'hE0FE); wr(4'h4, 16'h0200); wr(4'h6, 16'h02FE);
    rd(4'h0, 16'hE000);
    ctrl_commit(16'h0001, {16'hE000, 16'hE0FE, 16'h0200, 16'h02FE});
    rd(4'hA, 16'h0004);
    rd(4'hA, 16'h000C);
    rd(4'hA, 16'h0008);

    // Inverted ER range rejected
    wr(4'h0, 16'hE100);
    wr(4'h8, 16'h0001);
    rd(4'hA, 16'h000C);
    rd(4'hA, 16'h000A);
    idle();
    @(negedge clk);
    chk("err_bounds_unchanged", {er_min, er_max, or_min, or_max},
        {16'hE000, 16'hE0FE, 16'h0200, 16'h02FE});
    wr(4'h8, 16'h0002);
    rd(4'hA, 16'h0008);

    // OR overlapping ER rejected, then cleared
    wr(4'h0, 16'hE000); wr(4'h4, 16'hE080); wr(4'h6, 16'hE200);
    wr(4'h8, 16'h0001);
    idle(); idle();
    rd(4'hA, 16'h000A);
    wr(4'h8, 16'h0002);
    rd(4'hA, 16'h0008);

    // Shadow write during CHECK is dropped
    wr(4'h4, 16'h0200); wr(4'h6, 16'h02FE); wr(4'h0, 16'hE010);
    ctrl_commit(16'h0001, {16'hE010, 16'hE0FE, 16'h0200, 16'h02FE});
    wr(4'h0, 16'h1234);
    idle(); idle();
    rd(4'hA, 16'h0018);
    rd(4'h0, 16'hE010);
    idle();
    @(negedge clk);
    chk("drop_er_min", {48'h0, er_min}, 64'hE010);
    wr(4'h8, 16'h0002);
    rd(4'hA, 16'h0008);

    // Single-word ER touching OR_MAX fails; equal bounds clear of OR pass
    wr(4'h0, 16'h02FE); wr(4'h2, 16'h02FE);
    wr(4'h8, 16'h0001);
    idle(); idle();
    rd(4'hA, 16'h000A);
    wr(4'h8, 16'h0002);
    wr(4'h0, 16'h0300); wr(4'h2, 16'h0300);
    ctrl_commit(16'h0001, {16'h0300, 16'h0300, 16'h0200, 16'h02FE});
    idle(); idle(); idle();
    rd(4'hA, 16'h0008);

    // exec-time write behaviour
    idle();
    exec = 1'b1;
    wr(4'h6, 16'h0400);
`ifdef VAPE_META_LOCK_EN
    rd(4'hA, 16'h0019);
    rd(4'h6, 16'h02FE);
`else
    rd(4'hA, 16'h0009);
    rd(4'h6, 16'h0400);
`endif
    idle();
    exec = 1'b0;
    wr(4'h6, 16'h02FE);
    // COMMIT|CLR_ERR: clear first, then commit
    ctrl_commit(16'h0003, {16'h0300, 16'h0300, 16'h0200, 16'h02FE});
    idle(); idle(); idle();
    rd(4'hA, 16'h0008);

    // Reset during CHECK aborts the commit
    wr(4'h0, 16'h0500); wr(4'h2, 16'h0500);
    wr(4'h8, 16'h0001);
    reset_dut(2);
    @(negedge clk);
    chk("abort_bounds", {er_min, er_max, or_min, or_max}, 64'h0);
    chk("abort_cfg_valid", {63'h0, cfg_valid}, 64'h0);
    rd(4'hA, 16'h0000);
    rd(4'h0, 16'h0000);
    idle(); idle(); idle();
    @(negedge clk);
    chk("reads_drained", 64'(exp_q.size()), 64'h0);
    chk("commits_drained", 64'(exp_commit_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
